// File: rtl/nmcu_pkg.sv
// Shared NMCU types: arbiter state encoding and the controller's layer codes.
// Also provides a small modulo-increment helper.
package nmcu_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ARB_IDLE  = 2'd0;
    localparam arb_state_t ARB_ISSUE = 2'd1;
    localparam arb_state_t ARB_STALL = 2'd2;

    localparam logic [1:0] LAYER_CONV = 2'd0;
    localparam logic [1:0] LAYER_FC   = 2'd1;
    localparam logic [1:0] LAYER_POOL = 2'd2;
    localparam logic [1:0] LAYER_ACT  = 2'd3;

    function automatic int unsigned wrap_inc(int unsigned v, int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/nmcu_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping modulo N.
module nmcu_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);

    logic [IW:0] pos;

    // Scan from the farthest offset down so the nearest request wins last.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        pos     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            pos = {1'b0, ptr_i} + (IW + 1)'(i);
            if (pos >= (IW + 1)'(N)) begin
                pos = pos - (IW + 1)'(N);
            end
            if (req_i[pos[IW-1:0]]) begin
                valid_o = 1'b1;
                idx_o   = pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/nmcu_mem_arb.sv
// Round-robin arbiter sharing one memory port among NUM_NMCUS requesters.
// Optional watchdog on stuck accesses is enabled by defining NMCU_ARB_WDT_EN.
module nmcu_mem_arb
    import nmcu_pkg::*;
#(
    parameter int          NUM_NMCUS     = 4,
    parameter int          ADDR_WIDTH    = 16,
    parameter int          DATABUS_WIDTH = 32,
    parameter int unsigned WDT_CYCLES    = 255
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NUM_NMCUS-1:0]                     req_sel,
    input  logic [NUM_NMCUS-1:0]                     req_w,
    input  logic [NUM_NMCUS-1:0][ADDR_WIDTH-1:0]     req_addr,
    input  logic [NUM_NMCUS-1:0][DATABUS_WIDTH-1:0]  req_wdata,
    output logic [NUM_NMCUS-1:0]                     req_ready,
    output logic [DATABUS_WIDTH-1:0]                 req_rdata,
    output logic                                     mem_sel,
    output logic                                     mem_w,
    output logic [ADDR_WIDTH-1:0]                    mem_addr,
    output logic [DATABUS_WIDTH-1:0]                 mem_wdata,
    input  logic                                     mem_ready,
    input  logic [DATABUS_WIDTH-1:0]                 mem_rdata,
    output logic [$clog2(NUM_NMCUS)-1:0]             grant_idx,
    output logic                                     busy,
    output logic                                     err,
    output logic [$clog2(NUM_NMCUS)-1:0]             err_idx
);

    localparam int IW = $clog2(NUM_NMCUS);
    localparam logic [NUM_NMCUS-1:0] ONE = NUM_NMCUS'(1);

    arb_state_t               state_q, state_d;
    logic [IW-1:0]            ptr_q, ptr_d;
    logic [IW-1:0]            grant_q, grant_d;
    logic                     sel_q, sel_d;
    logic                     w_q, w_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [DATABUS_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATABUS_WIDTH-1:0] rdata_q, rdata_d;
    logic [NUM_NMCUS-1:0]     ready_q, ready_d;
    logic                     busy_q, busy_d;

    logic                     pick_vld;
    logic [IW-1:0]            pick_idx;
    logic                     wdt_hit;

    nmcu_rr_pick #(
        .N  (NUM_NMCUS),
        .IW (IW)
    ) u_pick (
        .req_i   (req_sel),
        .ptr_i   (ptr_q),
        .valid_o (pick_vld),
        .idx_o   (pick_idx)
    );

`ifdef NMCU_ARB_WDT_EN
    localparam int WW = $clog2(WDT_CYCLES + 1);

    logic [WW-1:0] wdt_q;
    logic          err_q;
    logic [IW-1:0] err_idx_q;

    assign wdt_hit = (state_q == ARB_ISSUE) && !mem_ready
                  && (wdt_q == WW'(WDT_CYCLES - 1));

    // Count ISSUE cycles; latch the offending requester on timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdt_q     <= '0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
        end else begin
            wdt_q <= (state_q == ARB_ISSUE) ? wdt_q + WW'(1) : '0;
            if (wdt_hit) begin
                err_q     <= 1'b1;
                err_idx_q <= grant_q;
            end
        end
    end

    assign err     = err_q;
    assign err_idx = err_idx_q;
`else
    assign wdt_hit = 1'b0;
    assign err     = 1'b0;
    assign err_idx = '0;
`endif

    // Next-state logic for the grant / issue / completion sequence.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        w_d     = w_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ready_d = ready_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_idx;
                    addr_d  = req_addr[pick_idx];
                    w_d     = req_w[pick_idx];
                    wdata_d = req_wdata[pick_idx];
                    sel_d   = 1'b1;
                    ptr_d   = (pick_idx == IW'(NUM_NMCUS - 1))
                            ? '0 : pick_idx + IW'(1);
                    state_d = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (mem_ready || wdt_hit) begin
                    rdata_d = mem_ready ? mem_rdata : '0;
                    ready_d = ONE << grant_q;
                    sel_d   = 1'b0;
                    w_d     = 1'b0;
                    state_d = ARB_STALL;
                end
            end
            ARB_STALL: begin
                ready_d = '0;
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
        busy_d = (state_d != ARB_IDLE);
    end

    // Register every output so nothing leaks combinationally from inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            sel_q   <= 1'b0;
            w_q     <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            w_q     <= w_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign req_ready = ready_q;
    assign req_rdata = rdata_q;
    assign mem_sel   = sel_q;
    assign mem_w     = w_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign grant_idx = grant_q;
    assign busy      = busy_q;

endmodule
